// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART transmitter state encoding and line defaults
package uart_pkg;

  localparam int   CLKS_PER_BIT_115200 = 1085;
  localparam logic UART_IDLE_LEVEL     = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - power-of-two transmit FIFO with occupancy count
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  // A write while full is dropped even if a pop frees a slot in the same cycle.
  assign full      = (r_count == LW'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_push_ok = push && !full;
  assign w_pop_ok  = pop && !empty;
  assign pop_data  = r_mem[r_rd_ptr];
  assign level     = r_count;

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointers are exactly AW bits wide, so increment wraps modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - buffered UART transmitter; define UART_TX_PARITY_EN for an even parity bit
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_BITS-1:0]          din,
  input  logic                          wen,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic                          busy,
  output logic                          tx_out
);

  localparam logic [2:0] S_IDLE   = ST_IDLE;
  localparam logic [2:0] S_START  = ST_START;
  localparam logic [2:0] S_DATA   = ST_DATA;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = ST_PARITY;
`endif
  localparam logic [2:0] S_STOP   = ST_STOP;

  localparam int CNT_W = $clog2(STOP_BITS * CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_RELOAD = CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(DATA_BITS - 1);

  logic [2:0]           r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_tx;
  logic                 r_overflow;
`ifdef UART_TX_PARITY_EN
  logic                 r_parity;
`endif

  logic                 w_full;
  logic                 w_empty;
  logic                 w_pop;
  logic [DATA_BITS-1:0] w_pop_data;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (wen),
    .push_data (din),
    .pop       (w_pop),
    .pop_data  (w_pop_data),
    .full      (w_full),
    .empty     (w_empty),
    .level     (level)
  );

  // Popping at the last STOP cycle chains the next start bit with no idle gap.
  assign w_pop = !w_empty && ((r_state == S_IDLE) ||
                              ((r_state == S_STOP) && (r_cnt == '0)));

  assign full     = w_full;
  assign empty    = w_empty;
  assign overflow = r_overflow;
  assign busy     = (r_state != S_IDLE);
  assign tx_out   = r_tx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= wen && w_full;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_shift  <= '0;
      r_tx     <= UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else if (w_pop) begin
      r_state  <= S_START;
      r_cnt    <= BIT_RELOAD;
      r_shift  <= w_pop_data;
      r_tx     <= ~UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
      r_parity <= ^w_pop_data;
`endif
    end else if (r_state != S_IDLE) begin
      if (r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end else begin
        case (r_state)
          S_START: begin
            r_state <= S_DATA;
            r_cnt   <= BIT_RELOAD;
            r_idx   <= '0;
            r_tx    <= r_shift[0];
            r_shift <= r_shift >> 1;
          end
          S_DATA: begin
            if (r_idx != LAST_IDX) begin
              r_idx   <= r_idx + 1'b1;
              r_cnt   <= BIT_RELOAD;
              r_tx    <= r_shift[0];
              r_shift <= r_shift >> 1;
            end else begin
`ifdef UART_TX_PARITY_EN
              r_state <= S_PARITY;
              r_cnt   <= BIT_RELOAD;
              r_tx    <= r_parity;
`else
              r_state <= S_STOP;
              r_cnt   <= STOP_RELOAD;
              r_tx    <= UART_IDLE_LEVEL;
`endif
            end
          end
`ifdef UART_TX_PARITY_EN
          S_PARITY: begin
            r_state <= S_STOP;
            r_cnt   <= STOP_RELOAD;
            r_tx    <= UART_IDLE_LEVEL;
          end
`endif
          S_STOP: begin
            r_state <= S_IDLE;
            r_tx    <= UART_IDLE_LEVEL;
          end
          default: begin
            r_state <= S_IDLE;
            r_tx    <= UART_IDLE_LEVEL;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 1085, clk cycles per serial bit (125 MHz / 115200 baud); legal range >= 2.
REQ-002 Parameter DATA_BITS, default 8, payload bits per frame; legal range 5..8.
REQ-003 Parameter FIFO_DEPTH, default 16, buffered entries; legal values are powers of two >= 2.
REQ-004 Parameter STOP_BITS, default 1, stop bits per frame; legal values are 1 or 2.
REQ-005 Port clk, input, 1, the single clock for the block; all logic is rising-edge.
REQ-006 Port rst_n, input, 1, asynchronous active-low reset.
REQ-007 Port din, input, DATA_BITS, write data.
REQ-008 Port wen, input, 1, write enable sampled each rising clk edge.
REQ-009 Port full, output, 1, FIFO holds FIFO_DEPTH entries.
REQ-010 Port empty, output, 1, FIFO holds 0 entries.
REQ-011 Port level, output, $clog2(FIFO_DEPTH)+1, current FIFO occupancy; excludes the frame in flight.
REQ-012 Port overflow, output, 1, one-cycle pulse for each rejected write.
REQ-013 Port busy, output, 1, transmitter is not in IDLE.
REQ-014 Port tx_out, output, 1, serial line; idles high.

Function
REQ-015 When wen=1 and full=0, din SHALL be stored at the tail; level increments on the next edge.
REQ-016 When wen=1 and full=1, the write SHALL be dropped and overflow pulses high on the next cycle; this holds even if a pop occurs in the same cycle.
REQ-017 Transmitter FSM states SHALL be: IDLE, START, DATA, PARITY, STOP.
REQ-018 In IDLE with empty=0, the head entry SHALL be popped into the shift register and the FSM enters START on the next edge.
REQ-019 START drives tx_out=0 for CLKS_PER_BIT cycles.
REQ-020 DATA shifts DATA_BITS bits LSB first, each held for CLKS_PER_BIT cycles.
REQ-021 PARITY is entered only when UART_TX_PARITY_EN is defined; otherwise DATA goes directly to STOP.
REQ-022 STOP drives tx_out=1 for STOP_BITS*CLKS_PER_BIT cycles.
REQ-023 At the end of STOP with empty=0, the FSM SHALL pop and enter START directly, with no idle gap; with empty=1 it enters IDLE.
REQ-024 A write into an empty FIFO is visible to the transmitter one cycle later; the same entry is never written and popped in one cycle.
REQ-025 A simultaneous write and pop with full=0 leaves level unchanged.
REQ-026 Read and write pointers wrap modulo FIFO_DEPTH.
REQ-027 Each bit period is counted by a down-counter reloaded at every bit boundary; there is no cumulative drift.

Reset
REQ-028 While rst_n=0, outputs SHALL be: tx_out=1, busy=0, empty=1, full=0, level=0, overflow=0; FIFO contents are discarded.
REQ-029 Reset mid-frame aborts the frame immediately, and tx_out returns high asynchronously.
REQ-030 After rst_n deasserts, the first transmission starts no earlier than the first accepted write.

Configuration
REQ-031 Macro UART_TX_PARITY_EN: when defined, one parity bit of CLKS_PER_BIT cycles follows DATA.
REQ-032 The parity bit equals XOR of the DATA_BITS payload bits (even parity).
REQ-033 When UART_TX_PARITY_EN is not defined, there is no parity state or logic and the frame is 1+DATA_BITS+STOP_BITS bits.

Structure
REQ-034 Package uart_pkg SHALL hold the FSM state enum and the defaults CLKS_PER_BIT_115200=1085 and UART_IDLE_LEVEL=1.
REQ-035 The FIFO SHALL be sub-module uart_tx_fifo (parameters DEPTH and WIDTH; ports for push, pop, full, empty, level); the FSM and bit counter stay in the top level.

Verification
REQ-036 With CLKS_PER_BIT=4, write "A" (0x41) -> after 1 cycle tx_out falls, giving the line sequence 0,1,0,0,0,0,0,1,0,1 with each bit lasting 4 cycles.
REQ-037 Write "A" then "B" on consecutive cycles -> two frames back-to-back with no idle between stop and start bits; empty=1 after the second pop.
REQ-038 Fill to FIFO_DEPTH plus 1 extra write while the transmitter is stalled mid-frame -> full=1, level=FIFO_DEPTH, one overflow pulse, and the extra byte is never transmitted.
REQ-039 With UART_TX_PARITY_EN defined, send 0x41 -> parity bit=0; send 0x43 -> parity bit=1.
REQ-040 Assert rst_n=0 during DATA -> tx_out=1 and busy=0 within the same cycle, and level=0 after release.
REQ-041 With STOP_BITS=2 and DATA_BITS=7, send 0x7F -> the frame lasts 10*CLKS_PER_BIT cycles.
